// File: rtl/minterm_lut_eval_if.sv
// Streaming handshake bundle for minterm_lut_eval: vector in, evaluated bit out.
interface minterm_lut_eval_if #(
    parameter int unsigned N_IN = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_y;
    logic [N_IN-1:0] out_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_y, out_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_y, out_idx
    );
endinterface

// File: rtl/minterm_lut_eval.sv
// Reloadable sum-of-minterms evaluator: handshaked single-entry eval path plus
// a sweep FSM that counts the on-set of the current mask.
module minterm_lut_eval #(
    parameter int unsigned          N_IN         = 3,
    parameter logic [(1<<N_IN)-1:0] DEFAULT_MASK = 8'h79
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic [(1<<N_IN)-1:0] cfg_mask,
    input  logic                 sweep_start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [N_IN:0]        sweep_count,
    minterm_lut_eval_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t               state;
    logic [(1<<N_IN)-1:0] mask;
    logic [N_IN:0]        idx;
    logic [N_IN:0]        acc;
    logic [N_IN:0]        acc_next;
    logic                 accept;

    assign bus.in_ready = ~sweep_busy & (~bus.out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign acc_next     = acc + {{N_IN{1'b0}}, mask[idx[N_IN-1:0]]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mask          <= DEFAULT_MASK;
            idx           <= '0;
            acc           <= '0;
            sweep_busy    <= 1'b0;
            sweep_done    <= 1'b0;
            sweep_count   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_y     <= 1'b0;
            bus.out_idx   <= '0;
        end else begin
            // Eval reads the mask as it stands this cycle, so a same-cycle
            // reload only affects later accepts.
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_y     <= mask[bus.in_data];
                bus.out_idx   <= bus.in_data;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            sweep_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        mask <= cfg_mask;
                    end else if (sweep_start) begin
                        state      <= SWEEP;
                        idx        <= '0;
                        acc        <= '0;
                        sweep_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == {1'b0, {N_IN{1'b1}}}) begin
                        state       <= DONE;
                        sweep_busy  <= 1'b0;
                        sweep_done  <= 1'b1;
                        sweep_count <= acc_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_minterm_lut_eval.sv
// Directed bench for minterm_lut_eval: default N_IN=3 instance plus an
// N_IN=4 all-ones instance.
module tb_minterm_lut_eval;
    logic clk;
    logic rst;

    logic       cfg_load_a;
    logic [7:0] cfg_mask_a;
    logic       sweep_start_a;
    logic       sweep_busy_a;
    logic       sweep_done_a;
    logic [3:0] sweep_count_a;

    logic        cfg_load_b;
    logic [15:0] cfg_mask_b;
    logic        sweep_start_b;
    logic        sweep_busy_b;
    logic        sweep_done_b;
    logic [4:0]  sweep_count_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    minterm_lut_eval_if #(.N_IN(3)) bus_a ();
    minterm_lut_eval_if #(.N_IN(4)) bus_b ();

    minterm_lut_eval #(.N_IN(3), .DEFAULT_MASK(8'h79)) dut_a (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load_a), .cfg_mask(cfg_mask_a),
        .sweep_start(sweep_start_a), .sweep_busy(sweep_busy_a),
        .sweep_done(sweep_done_a), .sweep_count(sweep_count_a),
        .bus(bus_a)
    );

    minterm_lut_eval #(.N_IN(4), .DEFAULT_MASK(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load_b), .cfg_mask(cfg_mask_b),
        .sweep_start(sweep_start_b), .sweep_busy(sweep_busy_b),
        .sweep_done(sweep_done_b), .sweep_count(sweep_count_b),
        .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits out a sweep on dut_a already in SWEEP; leaves time on the DONE cycle.
    task automatic wait_sweep_a(input string tag, input int exp_count);
        int n;
        n = 0;
        while (sweep_busy_a && n < 40) begin
            n++;
            step();
        end
        chk({tag, "_busy_cycles"}, n, 8);
        chk({tag, "_done"}, sweep_done_a, 1);
        chk({tag, "_count"}, sweep_count_a, exp_count);
    endtask

    initial begin
        int exp_y [8];
        int n;
        int pulses;
        exp_y = '{1, 0, 0, 1, 1, 1, 1, 0};

        rst = 1'b1;
        cfg_load_a = 1'b0; cfg_mask_a = '0; sweep_start_a = 1'b0;
        cfg_load_b = 1'b0; cfg_mask_b = '0; sweep_start_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_out_y", bus_a.out_y, 0);
        chk("rst_out_idx", bus_a.out_idx, 0);
        chk("rst_busy", sweep_busy_a, 0);
        chk("rst_done", sweep_done_a, 0);
        chk("rst_count", sweep_count_a, 0);
        chk("rst_in_ready", bus_a.in_ready, 1);

        // Back-to-back evaluation of the default mask
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = 3'(i);
            step();
            chk($sformatf("eval_valid_%0d", i), bus_a.out_valid, 1);
            chk($sformatf("eval_y_%0d", i), bus_a.out_y, exp_y[i]);
            chk($sformatf("eval_idx_%0d", i), bus_a.out_idx, i);
        end
        bus_a.in_valid = 1'b0;
        step();
        chk("eval_drain", bus_a.out_valid, 0);

        // Backpressure
        bus_a.in_valid = 1'b1; bus_a.in_data = 3'd3; bus_a.out_ready = 1'b0;
        step();
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_valid", bus_a.out_valid, 1);
            chk("bp_y", bus_a.out_y, 1);
            chk("bp_idx", bus_a.out_idx, 3);
            chk("bp_in_ready", bus_a.in_ready, 0);
            step();
        end
        bus_a.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus_a.in_ready, 1);
        step();
        chk("bp_release_valid", bus_a.out_valid, 0);

        // Reload in the same cycle as an accept
        bus_a.in_valid = 1'b1; bus_a.in_data = 3'd7;
        cfg_load_a = 1'b1; cfg_mask_a = 8'h80;
        step();
        cfg_load_a = 1'b0;
        chk("reload_old_mask_y", bus_a.out_y, 0);
        chk("reload_old_mask_idx", bus_a.out_idx, 7);
        step();
        chk("reload_new_mask_y", bus_a.out_y, 1);
        bus_a.in_valid = 1'b0;
        step();

        // cfg_load beats sweep_start in the same cycle
        cfg_load_a = 1'b1; cfg_mask_a = 8'h79; sweep_start_a = 1'b1;
        step();
        cfg_load_a = 1'b0; sweep_start_a = 1'b0;
        chk("cfg_priority_busy", sweep_busy_a, 0);
        step();
        chk("cfg_priority_busy2", sweep_busy_a, 0);

        // Sweeps over several masks
        sweep_start_a = 1'b1;
        step();
        sweep_start_a = 1'b0;
        wait_sweep_a("sweep79", 5);
        step();
        chk("sweep79_done_pulse", sweep_done_a, 0);
        chk("sweep79_count_hold", sweep_count_a, 5);

        cfg_load_a = 1'b1; cfg_mask_a = 8'hFF;
        step();
        cfg_load_a = 1'b0; sweep_start_a = 1'b1;
        step();
        sweep_start_a = 1'b0;
        wait_sweep_a("sweepFF", 8);
        step();

        cfg_load_a = 1'b1; cfg_mask_a = 8'h00;
        step();
        cfg_load_a = 1'b0; sweep_start_a = 1'b1;
        step();
        sweep_start_a = 1'b0;
        wait_sweep_a("sweep00", 0);
        step();

        // Config and input are ignored while a sweep runs
        cfg_load_a = 1'b1; cfg_mask_a = 8'h79;
        step();
        cfg_load_a = 1'b0; sweep_start_a = 1'b1;
        step();
        sweep_start_a = 1'b0;
        cfg_load_a = 1'b1; cfg_mask_a = 8'h01;
        bus_a.in_valid = 1'b1; bus_a.in_data = 3'd0;
        #1;
        chk("intf_in_ready", bus_a.in_ready, 0);
        wait_sweep_a("intf", 5);
        cfg_load_a = 1'b0; bus_a.in_valid = 1'b0;
        chk("intf_no_accept", bus_a.out_valid, 0);
        step();
        cfg_load_a = 1'b1; cfg_mask_a = 8'h01;
        step();
        cfg_load_a = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_data = 3'd0;
        step();
        chk("intf_after_y0", bus_a.out_y, 1);
        bus_a.in_data = 3'd3;
        step();
        chk("intf_after_y3", bus_a.out_y, 0);
        bus_a.in_valid = 1'b0;
        step();

        // Reset in the middle of a sweep
        sweep_start_a = 1'b1;
        step();
        sweep_start_a = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", sweep_busy_a, 0);
        chk("midrst_count", sweep_count_a, 0);
        chk("midrst_done", sweep_done_a, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (sweep_done_a) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        sweep_start_a = 1'b1;
        step();
        sweep_start_a = 1'b0;
        wait_sweep_a("midrst_mask", 5);
        step();

        // Four-input instance with an all-ones default mask
        sweep_start_b = 1'b1;
        step();
        sweep_start_b = 1'b0;
        n = 0;
        while (sweep_busy_b && n < 60) begin
            n++;
            step();
        end
        chk("n4_busy_cycles", n, 16);
        chk("n4_done", sweep_done_b, 1);
        chk("n4_count", sweep_count_b, 16);
        step();
        bus_b.out_ready = 1'b1; bus_b.in_valid = 1'b1; bus_b.in_data = 4'd15;
        step();
        bus_b.in_valid = 1'b0;
        chk("n4_eval_y", bus_b.out_y, 1);
        chk("n4_eval_idx", bus_b.out_idx, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
